// File: rtl/tpu_dma_pkg.sv
// Shared types and constants for the layer DMA responder: request modes,
// FSM states, per-layer transfer lengths and the length lookup helper.
package tpu_dma_pkg;

  localparam int LEN_W     = 11;
  localparam int LEN_CONV0 = 1176;
  localparam int LEN_CONV1 = 400;
  localparam int LEN_FC0   = 120;
  localparam int LEN_FC1   = 84;

  typedef enum logic [1:0] {
    DMA_NONE = 2'd0,
    DMA_CONV = 2'd1,
    DMA_FC   = 2'd2,
    DMA_ILL  = 2'd3
  } dma_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

  typedef struct packed {
    logic             legal;
    logic [LEN_W-1:0] len;
  } len_info_t;

  // Words to move for a given mode/layer; any unlisted combination is illegal.
  function automatic len_info_t len_lookup(input dma_mode_e mode, input logic [1:0] nth);
    len_info_t info;
    info.legal = 1'b0;
    info.len   = '0;
    case (mode)
      DMA_CONV: begin
        if (nth == 2'd0) begin
          info.legal = 1'b1;
          info.len   = LEN_W'(LEN_CONV0);
        end else if (nth == 2'd1) begin
          info.legal = 1'b1;
          info.len   = LEN_W'(LEN_CONV1);
        end
      end
      DMA_FC: begin
        if (nth == 2'd0) begin
          info.legal = 1'b1;
          info.len   = LEN_W'(LEN_FC0);
        end else if (nth == 2'd1) begin
          info.legal = 1'b1;
          info.len   = LEN_W'(LEN_FC1);
        end
      end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/tpu_dma_addr_gen.sv
// Read-side address generator: holds the latched transfer length, walks the
// word index from zero and flags the final read so the FSM can drain.
module tpu_dma_addr_gen
  import tpu_dma_pkg::*;
#(
  parameter int ADDR_W = LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              run_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] len_q;

  // Latch the length and restart the index on acceptance; step once per read,
  // holding on the last word so the index can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      len_q <= '0;
    end else if (load_i) begin
      idx   <= '0;
      len_q <= len_i;
    end else if (run_i && !last_o) begin
      idx <= idx + ADDR_W'(1);
    end
  end

  // Read strobe and address are only driven while the transfer is running.
  always_comb begin
    rd_en_o = run_i;
    addr_o  = run_i ? idx : '0;
    last_o  = run_i && (idx == (len_q - ADDR_W'(1)));
  end

endmodule

// File: rtl/tpu_layer_dma.sv
// Layer DMA responder: on a start edge from the layer controller, copies one
// layer's activations from the result SRAM into the next layer's input SRAM
// and pulses dma_done_o for DONE_HOLD cycles.
// Optional build macro TPU_DMA_PERF_CNT_EN adds the perf_cycles_o counter.
module tpu_layer_dma
  import tpu_dma_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int DONE_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        start_dma_i,
  input  logic [1:0]        nth_conv_i,
  output logic              dma_done_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              src_rd_en_o,
  output logic [ADDR_W-1:0] src_addr_o,
  input  logic [DATA_W-1:0] src_rdata_i,
  output logic              dst_wr_en_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [DATA_W-1:0] dst_wdata_o
`ifdef TPU_DMA_PERF_CNT_EN
  ,
  output logic [15:0]       perf_cycles_o
`endif
);

  localparam int HOLD_W = $clog2(DONE_HOLD + 1);

  dma_state_e        state;
  dma_state_e        state_nxt;
  logic              start_prev;
  logic              req_edge;
  len_info_t         req_info;
  logic              accept;
  logic              reject;
  logic              run;
  logic              last_rd;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_last;

  assign req_edge  = (start_dma_i != 2'd0) && !start_prev;
  assign req_info  = len_lookup(dma_mode_e'(start_dma_i), nth_conv_i);
  assign accept    = req_edge && (state == IDLE) && req_info.legal;
  assign reject    = req_edge && (state == IDLE) && !req_info.legal;
  assign hold_last = (hold_cnt == HOLD_W'(DONE_HOLD - 1));

  // Remember whether a request was present last cycle so a held level is one request.
  always_ff @(posedge clk) begin
    if (rst) start_prev <= 1'b0;
    else     start_prev <= (start_dma_i != 2'd0);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: legal edges start a copy, illegal ones go straight to the done window.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)      state_nxt = RUN;
        else if (reject) state_nxt = DONE;
      end
      RUN:     if (last_rd) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (hold_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy for the whole request, done across the hold window.
  always_comb begin
    busy_o     = (state != IDLE);
    dma_done_o = (state == DONE);
    run        = (state == RUN);
  end

  // Count cycles spent in the done window so it lasts exactly DONE_HOLD cycles.
  always_ff @(posedge clk) begin
    if (rst || (state != DONE)) hold_cnt <= '0;
    else                        hold_cnt <= hold_cnt + HOLD_W'(1);
  end

  // Illegal requests leave a sticky error that only reset clears.
  always_ff @(posedge clk) begin
    if (rst)         err_o <= 1'b0;
    else if (reject) err_o <= 1'b1;
  end

  tpu_dma_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .run_i   (run),
    .len_i   (ADDR_W'(req_info.len)),
    .rd_en_o (src_rd_en_o),
    .addr_o  (src_addr_o),
    .last_o  (last_rd)
  );

  // Each write trails its read by one cycle, when the SRAM data arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_wr_en_o <= 1'b0;
      dst_addr_o  <= '0;
    end else begin
      dst_wr_en_o <= src_rd_en_o;
      dst_addr_o  <= src_addr_o;
    end
  end

  assign dst_wdata_o = dst_wr_en_o ? src_rdata_i : '0;

`ifdef TPU_DMA_PERF_CNT_EN
  logic [15:0] run_cnt;
  logic [15:0] run_inc;

  assign run_inc = (run_cnt == 16'hFFFF) ? 16'hFFFF : (run_cnt + 16'd1);

  // Measure acceptance-to-last-write cycles, publishing the total on the drain cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt       <= '0;
      perf_cycles_o <= '0;
    end else if (accept) begin
      run_cnt       <= '0;
      perf_cycles_o <= '0;
    end else if ((state == RUN) || (state == DRAIN)) begin
      run_cnt <= run_inc;
      if (state == DRAIN) perf_cycles_o <= run_inc;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_layer_dma.sv
// Directed bench for tpu_layer_dma: conv/fc transfers, illegal requests,
// re-trigger during a transfer and reset mid-transfer.
`timescale 1ns/1ps
module tb_tpu_layer_dma;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 11;
  localparam int DONE_HOLD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        start_dma;
  logic [1:0]        nth_conv;
  logic              dma_done;
  logic              busy;
  logic              err;
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_rdata = '0;
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] dst_wdata;
`ifdef TPU_DMA_PERF_CNT_EN
  logic [15:0]       perf_cycles;
`endif

  int assertions = 0;
  int failures   = 0;

  int rd_cnt, rd_first, rd_last, addr_err;
  int wr_cnt, wr_first, wr_last, data_err, idle_err;
  int done_cnt, done_first, done_last, busy_low;
  int ctrl_layer = 0;

  tpu_layer_dma #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DONE_HOLD (DONE_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_dma_i (start_dma),
    .nth_conv_i  (nth_conv),
    .dma_done_o  (dma_done),
    .busy_o      (busy),
    .err_o       (err),
    .src_rd_en_o (src_rd_en),
    .src_addr_o  (src_addr),
    .src_rdata_i (src_rdata),
    .dst_wr_en_o (dst_wr_en),
    .dst_addr_o  (dst_addr),
    .dst_wdata_o (dst_wdata)
`ifdef TPU_DMA_PERF_CNT_EN
    ,
    .perf_cycles_o (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Result SRAM contents are a fixed function of the address.
  function automatic logic [7:0] mem_val(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] v;
    v = (a * 11'd7) + 11'd3;
    return v[7:0];
  endfunction

  // Result SRAM model: one-cycle read latency.
  always @(posedge clk) src_rdata <= src_rd_en ? mem_val(src_addr) : 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe ncyc cycles (cycle 0 = the request edge) and gather statistics.
  task automatic watch(input int ncyc);
    logic prev_done;
    rd_cnt = 0; rd_first = -1; rd_last = -1; addr_err = 0;
    wr_cnt = 0; wr_first = -1; wr_last = -1; data_err = 0; idle_err = 0;
    done_cnt = 0; done_first = -1; done_last = -1; busy_low = -1;
    prev_done = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      if (src_rd_en) begin
        if (src_addr !== ADDR_W'(rd_cnt)) addr_err++;
        if (rd_cnt == 0) rd_first = cyc;
        rd_last = cyc;
        rd_cnt++;
      end
      if (dst_wr_en) begin
        if (dst_addr !== ADDR_W'(wr_cnt) || dst_wdata !== mem_val(ADDR_W'(wr_cnt))) data_err++;
        if (wr_cnt == 0) wr_first = cyc;
        wr_last = cyc;
        wr_cnt++;
      end else if (dst_addr !== '0 || dst_wdata !== '0) begin
        idle_err++;
      end
      if (dma_done) begin
        if (done_cnt == 0) done_first = cyc;
        done_last = cyc;
        done_cnt++;
        if (prev_done) ctrl_layer++;
      end
      prev_done = dma_done;
      if (cyc > 0 && !busy && busy_low < 0) busy_low = cyc;
    end
  endtask

  // Issue a request held for three cycles while observing ncyc cycles.
  task automatic request(input logic [1:0] m, input logic [1:0] n, input int ncyc);
    tick();
    start_dma = m;
    nth_conv  = n;
    fork
      watch(ncyc);
      begin
        repeat (3) tick();
        start_dma = 2'd0;
      end
    join
  endtask

  task automatic test_reset();
    rst = 1'b1; start_dma = 2'd0; nth_conv = 2'd0;
    repeat (3) tick();
    @(negedge clk);
    assertions++; if (dma_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", dma_done); end
    assertions++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    assertions++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got %b want 0", err); end
    assertions++; if (src_rd_en !== 1'b0 || src_addr !== '0) begin failures++; $display("[TB] FAIL reset_src got %b/%0d want 0/0", src_rd_en, src_addr); end
    assertions++; if (dst_wr_en !== 1'b0 || dst_addr !== '0 || dst_wdata !== '0) begin failures++; $display("[TB] FAIL reset_dst got %b/%0d/%0d want 0/0/0", dst_wr_en, dst_addr, dst_wdata); end
    rst = 1'b0;
    tick();
    @(negedge clk);
    assertions++; if (busy !== 1'b0 || src_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle got busy=%b rd=%b want 0/0", busy, src_rd_en); end
  endtask

  task automatic test_conv();
    $display("[TB] conv mode1/nth1 transfer");
    request(2'd1, 2'd1, 406);
    assertions++; if (rd_cnt !== 400) begin failures++; $display("[TB] FAIL conv_rd_cnt got %0d want 400", rd_cnt); end
    assertions++; if (rd_first !== 1 || rd_last !== 400) begin failures++; $display("[TB] FAIL conv_rd_window got %0d..%0d want 1..400", rd_first, rd_last); end
    assertions++; if (addr_err !== 0) begin failures++; $display("[TB] FAIL conv_rd_addr got %0d bad want 0", addr_err); end
    assertions++; if (wr_cnt !== 400) begin failures++; $display("[TB] FAIL conv_wr_cnt got %0d want 400", wr_cnt); end
    assertions++; if (wr_first !== 2 || wr_last !== 401) begin failures++; $display("[TB] FAIL conv_wr_window got %0d..%0d want 2..401", wr_first, wr_last); end
    assertions++; if (data_err !== 0) begin failures++; $display("[TB] FAIL conv_wr_data got %0d bad want 0", data_err); end
    assertions++; if (idle_err !== 0) begin failures++; $display("[TB] FAIL conv_idle_dst got %0d nonzero want 0", idle_err); end
    assertions++; if (done_cnt !== 2 || done_first !== 402 || done_last !== 403) begin failures++; $display("[TB] FAIL conv_done got %0d cycles at %0d..%0d want 2 at 402..403", done_cnt, done_first, done_last); end
    assertions++; if (busy_low !== 404) begin failures++; $display("[TB] FAIL conv_busy_low got %0d want 404", busy_low); end
    assertions++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL conv_err got %b want 0", err); end
  endtask

  task automatic test_fc();
    int layer0;
    $display("[TB] fc mode2/nth1 transfer");
    layer0 = ctrl_layer;
    request(2'd2, 2'd1, 92);
    assertions++; if (wr_cnt !== 84 || rd_cnt !== 84) begin failures++; $display("[TB] FAIL fc_count got rd=%0d wr=%0d want 84/84", rd_cnt, wr_cnt); end
    assertions++; if (wr_last !== 85 || data_err !== 0) begin failures++; $display("[TB] FAIL fc_writes got last=%0d bad=%0d want 85/0", wr_last, data_err); end
    assertions++; if (done_cnt !== 2 || done_first !== 86) begin failures++; $display("[TB] FAIL fc_done got %0d at %0d want 2 at 86", done_cnt, done_first); end
    assertions++; if (ctrl_layer - layer0 !== 1) begin failures++; $display("[TB] FAIL fc_ctrl_advance got %0d want 1", ctrl_layer - layer0); end
    assertions++; if (busy_low !== 88) begin failures++; $display("[TB] FAIL fc_busy_low got %0d want 88", busy_low); end
  endtask

`ifdef TPU_DMA_PERF_CNT_EN
  task automatic test_perf();
    $display("[TB] perf counter mode2/nth0");
    request(2'd2, 2'd0, 128);
    assertions++; if (wr_cnt !== 120) begin failures++; $display("[TB] FAIL perf_wr_cnt got %0d want 120", wr_cnt); end
    assertions++; if (perf_cycles !== 16'd121) begin failures++; $display("[TB] FAIL perf_cycles got %0d want 121", perf_cycles); end
  endtask
`endif

  task automatic test_illegal(input logic [1:0] m, input logic [1:0] n);
    $display("[TB] illegal request mode%0d/nth%0d", m, n);
    request(m, n, 8);
    assertions++; if (rd_cnt !== 0 || wr_cnt !== 0) begin failures++; $display("[TB] FAIL ill_xfers got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt); end
    assertions++; if (done_cnt !== 2 || done_first !== 1 || done_last !== 2) begin failures++; $display("[TB] FAIL ill_done got %0d at %0d..%0d want 2 at 1..2", done_cnt, done_first, done_last); end
    assertions++; if (busy_low !== 3) begin failures++; $display("[TB] FAIL ill_busy_low got %0d want 3", busy_low); end
    assertions++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL ill_err got %b want 1", err); end
  endtask

  task automatic test_back_to_back();
    $display("[TB] re-trigger during 1176-word transfer");
    tick();
    start_dma = 2'd1;
    nth_conv  = 2'd0;
    fork
      watch(1184);
      begin
        repeat (3) tick();
        start_dma = 2'd0;
        repeat (47) tick();
        start_dma = 2'd2;
        nth_conv  = 2'd1;
        repeat (3) tick();
        start_dma = 2'd0;
        nth_conv  = 2'd0;
      end
    join
    assertions++; if (rd_cnt !== 1176 || wr_cnt !== 1176) begin failures++; $display("[TB] FAIL retrig_count got rd=%0d wr=%0d want 1176/1176", rd_cnt, wr_cnt); end
    assertions++; if (addr_err !== 0 || data_err !== 0) begin failures++; $display("[TB] FAIL retrig_data got addr=%0d data=%0d bad want 0/0", addr_err, data_err); end
    assertions++; if (done_cnt !== 2 || done_first !== 1178) begin failures++; $display("[TB] FAIL retrig_done got %0d at %0d want 2 at 1178", done_cnt, done_first); end
    assertions++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL retrig_err_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    $display("[TB] reset at cycle 100 of 1176-word transfer");
    tick();
    start_dma = 2'd1;
    nth_conv  = 2'd0;
    fork
      watch(110);
      begin
        repeat (3) tick();
        start_dma = 2'd0;
        repeat (97) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    join
    assertions++; if (rd_cnt !== 100 || rd_last !== 100) begin failures++; $display("[TB] FAIL rstmid_reads got %0d last %0d want 100 last 100", rd_cnt, rd_last); end
    assertions++; if (wr_cnt !== 99 || wr_last !== 100) begin failures++; $display("[TB] FAIL rstmid_writes got %0d last %0d want 99 last 100", wr_cnt, wr_last); end
    assertions++; if (done_cnt !== 0 || busy_low !== 101) begin failures++; $display("[TB] FAIL rstmid_done_busy got done=%0d busy_low=%0d want 0/101", done_cnt, busy_low); end
    assertions++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_err got %b want 0", err); end
    request(2'd1, 2'd0, 1184);
    assertions++; if (rd_cnt !== 1176 || wr_cnt !== 1176) begin failures++; $display("[TB] FAIL fresh_count got rd=%0d wr=%0d want 1176/1176", rd_cnt, wr_cnt); end
    assertions++; if (data_err !== 0 || wr_last !== 1177) begin failures++; $display("[TB] FAIL fresh_writes got bad=%0d last=%0d want 0/1177", data_err, wr_last); end
    assertions++; if (done_first !== 1178 || busy_low !== 1180) begin failures++; $display("[TB] FAIL fresh_done_busy got %0d/%0d want 1178/1180", done_first, busy_low); end
  endtask

  initial begin
    test_reset();
    test_conv();
    test_fc();
`ifdef TPU_DMA_PERF_CNT_EN
    test_perf();
`endif
    test_illegal(2'd3, 2'd0);
    test_illegal(2'd2, 2'd2);
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
